edge_count_capture: RTL and testbench

//  Downstream consumer of the measurement sequencer's reset/start strobes.

---
 rtl/edge_count_capture_if.sv | 22 ++
 rtl/edge_count_capture.sv | 158 +++++++++++++++
 tb/tb_edge_count_capture.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_count_capture_if.sv
// Result channel from edge_count_capture toward the readout logic.
// The master drives the result fields and valid; the slave returns ready.
interface edge_count_capture_if #(
   parameter int CNT_W = 16,
   parameter int ID_W  = 8
) ();
   logic             result_valid;
   logic             result_ready;
   logic [CNT_W-1:0] result_count;
   logic             result_sat;
   logic [ID_W-1:0]  result_id;

   modport master (
      output result_valid, result_count, result_sat, result_id,
      input  result_ready
   );

   modport slave (
      input  result_valid, result_count, result_sat, result_id,
      output result_ready
   );
endinterface

// File: rtl/edge_count_capture.sv
// Counts synchronized rising edges of i_sig_in inside a sequencer-defined
// window and publishes one saturating count per run over a valid/ready channel.
module edge_count_capture #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int ID_W        = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_meas_reset,
   input  logic                 i_meas_start,
   input  logic                 i_sig_in,
   edge_count_capture_if.master res_if,
   output logic                 o_run_dropped,
   output logic                 o_busy
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      COUNT = 2'd2,
      PUB   = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;
   logic                   r_mr_d;
   logic                   r_ignore;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_sat;
   logic [CNT_W-1:0]       r_res_count;
   logic                   r_res_sat;
   logic [ID_W-1:0]        r_res_id;
   logic [ID_W-1:0]        r_id;
   logic                   r_valid;
   logic                   r_busy;
   logic                   r_dropped;

   logic                   w_edge;
   logic                   w_mr_rise;
   logic                   w_hs;
   logic                   w_cnt_en;
   logic                   w_publish;
   logic                   w_drop;

   assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_dly;
   assign w_mr_rise = i_meas_reset & ~r_mr_d;
   assign w_hs      = r_valid & res_if.result_ready;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; an abort in COUNT takes priority over closing the window
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (i_meas_reset && !r_ignore) w_state_nxt = CLEAR;
            else                           w_state_nxt = IDLE;
         end
         CLEAR: begin
            if (i_meas_start && !i_meas_reset) w_state_nxt = COUNT;
            else                               w_state_nxt = CLEAR;
         end
         COUNT: begin
            if (i_meas_reset)       w_state_nxt = CLEAR;
            else if (!i_meas_start) w_state_nxt = PUB;
            else                    w_state_nxt = COUNT;
         end
         PUB: begin
            if (w_hs) w_state_nxt = IDLE;
            else      w_state_nxt = PUB;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Per-state control strobes for the datapath
   always_comb begin
      w_cnt_en  = 1'b0;
      w_publish = 1'b0;
      w_drop    = 1'b0;
      case (r_state)
         COUNT: begin
            w_cnt_en  = i_meas_start & ~i_meas_reset & w_edge;
            w_publish = ~i_meas_start & ~i_meas_reset;
         end
         PUB: begin
            w_drop = w_mr_rise & ~w_hs;
         end
         default: begin
            w_cnt_en = 1'b0;
         end
      endcase
   end

   // Synchronizer, counter, result capture and registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync      <= '0;
         r_dly       <= 1'b0;
         r_mr_d      <= 1'b0;
         r_ignore    <= 1'b0;
         r_cnt       <= '0;
         r_sat       <= 1'b0;
         r_res_count <= '0;
         r_res_sat   <= 1'b0;
         r_res_id    <= '0;
         r_id        <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_dropped   <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
         r_dly     <= r_sync[SYNC_STAGES-1];
         r_mr_d    <= i_meas_reset;
         r_valid   <= (w_state_nxt == PUB);
         r_busy    <= (w_state_nxt != IDLE);
         r_dropped <= w_drop;
         // A dropped run's meas_reset must fall before IDLE accepts a new one
         if (w_drop) begin
            r_ignore <= 1'b1;
         end else if (!i_meas_reset) begin
            r_ignore <= 1'b0;
         end
         if (w_state_nxt != COUNT) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
         end else if (w_cnt_en) begin
            if (r_cnt == {CNT_W{1'b1}}) begin
               r_sat <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
         if (w_publish) begin
            r_res_count <= r_cnt;
            r_res_sat   <= r_sat;
            r_res_id    <= r_id;
            r_id        <= r_id + ID_W'(1);
         end
      end
   end

   assign res_if.result_valid = r_valid;
   assign res_if.result_count = r_res_count;
   assign res_if.result_sat   = r_res_sat;
   assign res_if.result_id    = r_res_id;
   assign o_run_dropped       = r_dropped;
   assign o_busy              = r_busy;
endmodule

// File: tb/tb_edge_count_capture.sv
// Directed bench for edge_count_capture: a wide instance and a narrow one
// (4-bit count, 2-bit id) share stimulus; results are checked via scoreboards.
module tb_edge_count_capture;
   typedef struct {
      int count;
      int sat;
      int id;
   } exp_t;

   logic clk;
   logic rst;
   logic meas_reset;
   logic meas_start;
   logic sig_in;
   logic ready;
   logic drop_a, drop_b, busy_a, busy_b;

   int n_checks = 0;
   int n_fail   = 0;
   int model_id = 0;
   int valid_cyc_a = 0;
   int valid_cyc_b = 0;
   int drops_a = 0;
   int drops_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;

   edge_count_capture_if #(.CNT_W(16), .ID_W(8)) bus_a ();
   edge_count_capture_if #(.CNT_W(4),  .ID_W(2)) bus_b ();
   assign bus_a.result_ready = ready;
   assign bus_b.result_ready = ready;

   edge_count_capture #(.CNT_W(16), .SYNC_STAGES(2), .ID_W(8)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_meas_reset(meas_reset), .i_meas_start(meas_start),
      .i_sig_in(sig_in), .res_if(bus_a), .o_run_dropped(drop_a), .o_busy(busy_a)
   );

   edge_count_capture #(.CNT_W(4), .SYNC_STAGES(2), .ID_W(2)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_meas_reset(meas_reset), .i_meas_start(meas_start),
      .i_sig_in(sig_in), .res_if(bus_b), .o_run_dropped(drop_b), .o_busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset(input int n);
      meas_reset = 1'b1;
      tick(n);
      meas_reset = 1'b0;
   endtask

   task automatic edges(input int n, input int period);
      for (int k = 0; k < n; k++) begin
         sig_in = 1'b1;
         tick(period / 2);
         sig_in = 1'b0;
         tick(period - period / 2);
      end
   endtask

   task automatic window(input int n, input int period);
      meas_start = 1'b1;
      tick(4);
      edges(n, period);
      tick(6);
      meas_start = 1'b0;
   endtask

   task automatic push_run(input int n);
      exp_t ea, eb;
      ea.count = (n > 65535) ? 65535 : n;
      ea.sat   = (n > 65535) ? 1 : 0;
      ea.id    = model_id % 256;
      eb.count = (n > 15) ? 15 : n;
      eb.sat   = (n > 15) ? 1 : 0;
      eb.id    = model_id % 4;
      q_a.push_back(ea);
      q_b.push_back(eb);
      model_id++;
   endtask

   task automatic run(input int rst_len, input int n, input int period);
      pulse_reset(rst_len);
      tick(1);
      window(n, period);
      push_run(n);
   endtask

   // Scoreboard and event counters, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_a.result_valid) valid_cyc_a++;
         if (bus_b.result_valid) valid_cyc_b++;
         if (drop_a) drops_a++;
         if (drop_b) drops_b++;
         if (bus_a.result_valid && ready) begin
            if (q_a.size() == 0) begin
               check("a_unexpected_result", 1, 0);
            end else begin
               e_a = q_a.pop_front();
               check("a_count", bus_a.result_count, e_a.count);
               check("a_sat", bus_a.result_sat, e_a.sat);
               check("a_id", bus_a.result_id, e_a.id);
            end
         end
         if (bus_b.result_valid && ready) begin
            if (q_b.size() == 0) begin
               check("b_unexpected_result", 1, 0);
            end else begin
               e_b = q_b.pop_front();
               check("b_count", bus_b.result_count, e_b.count);
               check("b_sat", bus_b.result_sat, e_b.sat);
               check("b_id", bus_b.result_id, e_b.id);
            end
         end
      end
   end

   initial begin
      int v0;
      int d0;
      rst        = 1'b1;
      meas_reset = 1'b0;
      meas_start = 1'b0;
      sig_in     = 1'b0;
      ready      = 1'b1;
      tick(2);
      check("rst_valid", bus_a.result_valid, 0);
      check("rst_count", bus_a.result_count, 0);
      check("rst_id", bus_a.result_id, 0);
      check("rst_busy", busy_a, 0);
      check("rst_drop", drop_a, 0);
      rst = 1'b0;
      tick(2);

      // Long run: 100 edges at period 10 after a 128-cycle reset strobe
      v0 = valid_cyc_a;
      run(128, 100, 10);
      tick(10);
      check("t1_valid_len", valid_cyc_a - v0, 1);
      check("t1_drained", q_a.size(), 0);
      check("t1_idle", busy_a, 0);

      // Back-to-back runs with ready held high
      v0 = valid_cyc_a;
      run(8, 7, 8);
      tick(4);
      check("t2_valid_len_a", valid_cyc_a - v0, 1);
      v0 = valid_cyc_b;
      run(8, 12, 6);
      tick(4);
      check("t2_valid_len_b", valid_cyc_b - v0, 1);
      check("t2_drained", q_a.size() + q_b.size(), 0);

      // Saturation on the narrow instance, then id wrap on its 2-bit id
      run(8, 30, 8);
      tick(4);
      run(8, 3, 8);
      tick(4);
      check("t3_drained", q_a.size() + q_b.size(), 0);

      // Held result, second meas_reset is dropped, then a single handshake
      ready = 1'b0;
      run(8, 9, 8);
      tick(5);
      check("t4_valid_held", bus_a.result_valid, 1);
      d0 = drops_a;
      v0 = drops_b;
      pulse_reset(4);
      window(5, 8);
      tick(3);
      check("t4_drop_once_a", drops_a - d0, 1);
      check("t4_drop_once_b", drops_b - v0, 1);
      check("t4_count_stable", bus_a.result_count, 9);
      check("t4_id_stable", bus_a.result_id, (model_id - 1) % 256);
      check("t4_still_valid", bus_a.result_valid, 1);
      ready = 1'b1;
      tick(3);
      check("t4_valid_drop", bus_a.result_valid, 0);
      check("t4_idle", busy_a, 0);
      check("t4_drained", q_a.size() + q_b.size(), 0);
      tick(10);
      check("t4_no_late_result", bus_a.result_valid, 0);

      // Abort after 20 edges, then a fresh 5-edge window
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      model_id = 0;
      tick(2);
      pulse_reset(8);
      tick(1);
      meas_start = 1'b1;
      tick(4);
      edges(20, 8);
      meas_reset = 1'b1;
      meas_start = 1'b0;
      tick(5);
      check("t5_abort_no_valid", bus_a.result_valid, 0);
      check("t5_abort_busy", busy_a, 1);
      meas_reset = 1'b0;
      tick(1);
      window(5, 8);
      push_run(5);
      tick(6);
      check("t5_drained", q_a.size() + q_b.size(), 0);

      // rst mid-COUNT, then a window without meas_reset yields nothing
      pulse_reset(8);
      tick(1);
      meas_start = 1'b1;
      tick(4);
      edges(10, 8);
      check("t6_busy_before", busy_a, 1);
      rst = 1'b1;
      #1;
      check("t6_count_rst_busy", busy_a, 0);
      check("t6_count_rst_valid", bus_a.result_valid, 0);
      tick(2);
      rst = 1'b0;
      meas_start = 1'b0;
      model_id = 0;
      tick(2);
      window(5, 8);
      tick(10);
      check("t6_no_result", bus_a.result_valid, 0);
      check("t6_no_busy", busy_a, 0);

      // rst while a result is pending
      ready = 1'b0;
      run(8, 4, 8);
      tick(3);
      check("t6_pub_valid", bus_a.result_valid, 1);
      rst = 1'b1;
      #1;
      check("t6_pub_rst_valid", bus_a.result_valid, 0);
      check("t6_pub_rst_count", bus_a.result_count, 0);
      check("t6_pub_rst_sat", bus_b.result_sat, 0);
      check("t6_pub_rst_busy", busy_a, 0);
      q_a.delete();
      q_b.delete();
      model_id = 0;
      tick(2);
      rst = 1'b0;
      ready = 1'b1;
      tick(4);
      check("t6_final_idle", bus_a.result_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
